// File: rtl/riscv_writeback.sv
// Write-back stage: merges ALU and long-latency results onto the regfile write port.
// Tracks pending long-latency destinations so decode can stall on RAW/WAW.
module riscv_writeback #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_value_i,
    output logic            alu_ready_o,
    input  logic            lsu_valid_i,
    input  logic [4:0]      lsu_rd_i,
    input  logic [XLEN-1:0] lsu_value_i,
    output logic            lsu_ready_o,
    input  logic            issue_valid_i,
    input  logic [4:0]      issue_rd_i,
    input  logic [4:0]      ra_i,
    input  logic [4:0]      rb_i,
    output logic            hazard_o,
    output logic [4:0]      rd0_o,
    output logic [XLEN-1:0] rd0_value_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [4:0]      r_fifo_rd  [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_val [FIFO_DEPTH];
    logic [31:0]     r_pending;
    logic [4:0]      r_rd0;
    logic [XLEN-1:0] r_rd0_value;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_val;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = lsu_valid_i & ~w_full;
    // A full FIFO outranks the ALU so long-latency results cannot starve.
    assign w_pop      = w_full | (~alu_valid_i & ~w_empty);
    assign w_head_rd  = r_fifo_rd[r_rd_ptr];
    assign w_head_val = r_fifo_val[r_rd_ptr];

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid_i && issue_rd_i != 5'd0 && !r_pending[issue_rd_i])
            w_set[issue_rd_i] = 1'b1;
        if (w_pop)
            w_clr[w_head_rd] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pending   <= '0;
            r_rd0       <= '0;
            r_rd0_value <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_rd[i]  <= '0;
                r_fifo_val[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_rd[r_wr_ptr]  <= lsu_rd_i;
                r_fifo_val[r_wr_ptr] <= lsu_value_i;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;

            r_pending <= (r_pending & ~w_clr) | w_set;

            if (w_full) begin
                r_rd0       <= w_head_rd;
                r_rd0_value <= w_head_val;
            end else if (alu_valid_i) begin
                r_rd0       <= alu_rd_i;
                r_rd0_value <= alu_value_i;
            end else if (!w_empty) begin
                r_rd0       <= w_head_rd;
                r_rd0_value <= w_head_val;
            end else begin
                r_rd0       <= '0;
                r_rd0_value <= '0;
            end
        end
    end

    assign lsu_ready_o = ~w_full;
    assign alu_ready_o = ~w_full;
    assign rd0_o       = r_rd0;
    assign rd0_value_o = r_rd0_value;

    assign hazard_o = (ra_i != 5'd0 && r_pending[ra_i])
                    | (rb_i != 5'd0 && r_pending[rb_i])
                    | (issue_valid_i && r_pending[issue_rd_i]);

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed bench for riscv_writeback with a queue-based reference model
// compared every cycle, plus literal checks at key points.
module tb_riscv_writeback;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            alu_valid_i = 1'b0;
    logic [4:0]      alu_rd_i = '0;
    logic [XLEN-1:0] alu_value_i = '0;
    logic            alu_ready_o;
    logic            lsu_valid_i = 1'b0;
    logic [4:0]      lsu_rd_i = '0;
    logic [XLEN-1:0] lsu_value_i = '0;
    logic            lsu_ready_o;
    logic            issue_valid_i = 1'b0;
    logic [4:0]      issue_rd_i = '0;
    logic [4:0]      ra_i = '0;
    logic [4:0]      rb_i = '0;
    logic            hazard_o;
    logic [4:0]      rd0_o;
    logic [XLEN-1:0] rd0_value_o;

    int checks = 0;
    int errors = 0;

    riscv_writeback #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i),
        .alu_value_i(alu_value_i), .alu_ready_o(alu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i),
        .lsu_value_i(lsu_value_i), .lsu_ready_o(lsu_ready_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .ra_i(ra_i), .rb_i(rb_i), .hazard_o(hazard_o),
        .rd0_o(rd0_o), .rd0_value_o(rd0_value_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
    } res_t;

    res_t            m_q[$];
    bit              m_pend[32];
    logic [4:0]      m_rd0;
    logic [XLEN-1:0] m_val;

    // Reference: a queue of results, a per-register pending flag, and
    // the priority rule "full FIFO, then ALU, then FIFO, else idle".
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_q.delete();
            foreach (m_pend[i]) m_pend[i] = 0;
            m_rd0 = 0;
            m_val = 0;
        end else begin
            int  n;
            bit  do_set;
            res_t r;
            n = m_q.size();
            do_set = issue_valid_i && issue_rd_i != 0 && !m_pend[issue_rd_i];
            if (n == DEPTH || (!alu_valid_i && n > 0)) begin
                r = m_q.pop_front();
                m_rd0 = r.rd;
                m_val = r.val;
                m_pend[r.rd] = 0;
            end else if (alu_valid_i) begin
                m_rd0 = alu_rd_i;
                m_val = alu_value_i;
            end else begin
                m_rd0 = 0;
                m_val = 0;
            end
            if (lsu_valid_i && n != DEPTH) begin
                r.rd = lsu_rd_i;
                r.val = lsu_value_i;
                m_q.push_back(r);
            end
            if (do_set) m_pend[issue_rd_i] = 1;
        end
    end

    function automatic bit m_hazard();
        return (ra_i != 0 && m_pend[ra_i]) || (rb_i != 0 && m_pend[rb_i])
            || (issue_valid_i && m_pend[issue_rd_i]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        chk("cyc_rd0", 32'(rd0_o), 32'(m_rd0));
        chk("cyc_val", rd0_value_o, m_val);
        chk("cyc_lsu_ready", 32'(lsu_ready_o), 32'(m_q.size() != DEPTH));
        chk("cyc_alu_ready", 32'(alu_ready_o), 32'(m_q.size() != DEPTH));
        chk("cyc_hazard", 32'(hazard_o), 32'(m_hazard()));
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic alu(input bit v, input logic [4:0] rd, input logic [31:0] val);
        alu_valid_i = v; alu_rd_i = rd; alu_value_i = val;
    endtask

    task automatic lsu(input bit v, input logic [4:0] rd, input logic [31:0] val);
        lsu_valid_i = v; lsu_rd_i = rd; lsu_value_i = val;
    endtask

    task automatic issue(input bit v, input logic [4:0] rd);
        issue_valid_i = v; issue_rd_i = rd;
    endtask

    initial begin
        // Reset and idle
        step(); step();
        rst_i = 1'b1;
        step(); step();
        chk("rst_rd0", 32'(rd0_o), 0);
        chk("rst_val", rd0_value_o, 0);
        chk("rst_lsu_ready", 32'(lsu_ready_o), 1);
        chk("rst_alu_ready", 32'(alu_ready_o), 1);
        chk("rst_hazard", 32'(hazard_o), 0);

        // Single ALU result
        alu(1, 5, 32'h11111111);
        step();
        alu(0, 0, 0);
        chk("alu_rd0", 32'(rd0_o), 5);
        chk("alu_val", rd0_value_o, 32'h11111111);
        step();
        chk("alu_idle_rd0", 32'(rd0_o), 0);

        // RAW on a pending load, then its drain
        issue(1, 10);
        step();
        issue(0, 0);
        ra_i = 10;
        #1 chk("raw_hazard", 32'(hazard_o), 1);
        lsu(1, 10, 32'hAAAA5555);
        step();
        lsu(0, 0, 0);
        chk("lsu_lat1_rd0", 32'(rd0_o), 0);
        chk("lsu_lat1_hazard", 32'(hazard_o), 1);
        step();
        chk("lsu_rd0", 32'(rd0_o), 10);
        chk("lsu_val", rd0_value_o, 32'hAAAA5555);
        chk("lsu_hazard_clr", 32'(hazard_o), 0);
        ra_i = 0;

        // WAW: second issue to the same rd
        issue(1, 3);
        step();
        #1 chk("waw_hazard", 32'(hazard_o), 1);
        step();
        issue(0, 0);
        lsu(1, 3, 32'h33);
        step();
        lsu(0, 0, 0);
        step();
        chk("waw_rd0", 32'(rd0_o), 3);
        rb_i = 3;
        #1 chk("waw_single_set", 32'(hazard_o), 0);
        rb_i = 0;

        // FIFO fills while the ALU is busy every cycle
        issue(1, 4);
        step();
        issue(1, 6);
        step();
        issue(0, 0);
        alu(1, 7, 32'h70);
        lsu(1, 4, 32'h44);
        step();
        chk("fill_alu1", 32'(rd0_o), 7);
        alu(1, 8, 32'h80);
        lsu(1, 6, 32'h66);
        step();
        chk("fill_alu2", 32'(rd0_o), 8);
        lsu(0, 0, 0);
        alu(1, 9, 32'h90);
        #1;
        chk("full_lsu_ready", 32'(lsu_ready_o), 0);
        chk("full_alu_ready", 32'(alu_ready_o), 0);
        step();
        chk("full_pop_rd0", 32'(rd0_o), 4);
        chk("full_pop_val", rd0_value_o, 32'h44);
        step();
        chk("held_alu_rd0", 32'(rd0_o), 9);
        chk("held_alu_val", rd0_value_o, 32'h90);
        alu(0, 0, 0);
        step();
        chk("drain6_rd0", 32'(rd0_o), 6);
        chk("drain6_val", rd0_value_o, 32'h66);
        step();
        chk("drain_idle", 32'(rd0_o), 0);

        // Issue and result to x0
        issue(1, 0);
        lsu(1, 0, 32'h5A);
        #1 chk("x0_hazard", 32'(hazard_o), 0);
        step();
        issue(0, 0);
        lsu(0, 0, 0);
        step();
        chk("x0_rd0", 32'(rd0_o), 0);
        chk("x0_val", rd0_value_o, 32'h5A);

        // Reset with two entries queued
        issue(1, 12);
        step();
        issue(1, 13);
        step();
        issue(0, 0);
        alu(1, 1, 32'h1);
        lsu(1, 12, 32'hC);
        step();
        alu(1, 2, 32'h2);
        lsu(1, 13, 32'hD);
        step();
        lsu(0, 0, 0);
        alu(0, 0, 0);
        ra_i = 12;
        #1 chk("pre_rst_full", 32'(lsu_ready_o), 0);
        chk("pre_rst_hazard", 32'(hazard_o), 1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_lsu_ready", 32'(lsu_ready_o), 1);
        chk("mid_rst_hazard", 32'(hazard_o), 0);
        chk("mid_rst_rd0", 32'(rd0_o), 0);
        step();
        rst_i = 1'b1;
        step(); step(); step();
        chk("post_rst_rd0", 32'(rd0_o), 0);
        chk("post_rst_val", rd0_value_o, 0);
        ra_i = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
